// File: rtl/ibex_to_wb_master.sv
// Ibex core-side req/gnt/rvalid port to pipelined Wishbone B4 master bridge.
// Latency: gnt in N -> wb_stb_o in N+1; wb ack/err in M -> rvalid_o in M+1.
// Backpressure: wb_stall_i holds the strobe stable; gnt_o drops while stalled or when MAX_OUTSTANDING are in flight.
// Optional watchdog: define IBEX_WB_TIMEOUT_EN to answer hung transactions with a synthetic error response.
module ibex_to_wb_master #(
  parameter  int ADDR_W          = 32,
  parameter  int DATA_W          = 32,
  parameter  int MAX_OUTSTANDING = 2,
  parameter  int TIMEOUT_CYCLES  = 256,
  localparam int SEL_W           = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // core side
  input  logic              req_i,
  output logic              gnt_o,
  input  logic              we_i,
  input  logic [SEL_W-1:0]  be_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  // wishbone side
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [SEL_W-1:0]  wb_sel_o,
  output logic [DATA_W-1:0] wb_dat_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic              wb_ack_i,
  input  logic              wb_err_i,
  input  logic              wb_stall_i
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W:0] MAX_V = (CNT_W + 1)'(MAX_OUTSTANDING);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] dat;
  } hdr_t;

  // request holding register: one pending (granted, not yet issued) request
  logic             stb_q;
  hdr_t             hold_q;
  // transactions issued on the bus and still waiting for ack/err
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  // response registers
  logic              rvalid_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;

  logic [CNT_W:0] inflight;
  logic           gnt;
  logic           issue;
  logic           bus_resp;
  logic           to_fire;
  logic           resp;

  // Pending request counts against the limit so a grant never overflows cnt_q.
  assign inflight = {1'b0, cnt_q} + {{CNT_W{1'b0}}, stb_q};
  assign gnt      = req_i & (~stb_q | ~wb_stall_i) & (inflight < MAX_V);
  assign issue    = stb_q & ~wb_stall_i;
  // Acks with nothing in flight are spurious and dropped.
  assign bus_resp = (wb_ack_i | wb_err_i) & (cnt_q != '0);
  assign resp     = bus_resp | to_fire;

`ifdef IBEX_WB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_q;

  // Fires on the TIMEOUT_CYCLES-th consecutive cycle without a response.
  assign to_fire = (cnt_q != '0) & ~bus_resp & (wd_q == WD_LAST);

  // Watchdog: counts silent cycles while something is in flight, restarts on any response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_q <= '0;
    end else if ((cnt_q == '0) || resp) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + WD_W'(1);
    end
  end
`else
  assign to_fire = 1'b0;
`endif

  // In-flight counter: simultaneous issue and response cancel out.
  always_comb begin
    cnt_d = cnt_q;
    if (issue && !resp) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!issue && resp) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Holding register: a new grant may overwrite in the cycle the old request issues.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stb_q  <= 1'b0;
      hold_q <= '0;
    end else if (gnt) begin
      stb_q      <= 1'b1;
      hold_q.we  <= we_i;
      hold_q.adr <= addr_i;
      hold_q.sel <= be_i;
      hold_q.dat <= wdata_i;
    end else if (issue) begin
      stb_q <= 1'b0;
    end
  end

  // Issued-transaction counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Response register: one-cycle rvalid pulse, rdata/err hold between pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= resp;
      if (resp) begin
        rdata_q <= to_fire ? '0 : wb_dat_i;
        err_q   <= to_fire | wb_err_i;
      end
    end
  end

  assign gnt_o    = gnt;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

  assign wb_cyc_o = stb_q | (cnt_q != '0);
  assign wb_stb_o = stb_q;
  assign wb_we_o  = hold_q.we;
  assign wb_adr_o = hold_q.adr;
  assign wb_sel_o = hold_q.sel;
  assign wb_dat_o = hold_q.dat;

endmodule

// File: tb/tb_ibex_to_wb_master.sv
// Self-checking bench for ibex_to_wb_master: directed scenarios then random traffic.
// A transaction-level model (pending request + queue of issued addresses) predicts every output.
// Wishbone slave and core are both driven from the bench.
module tb_ibex_to_wb_master;

  localparam int MAX = 2;
  localparam int TO  = 8;

  logic        clk = 1'b0;
  logic        rst, req, we, stall, ack, err;
  logic [3:0]  be;
  logic [31:0] addr, wdata, dat;

  logic        gnt_o, rvalid_o, err_o;
  logic [31:0] rdata_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;

  int total = 0;
  int bad   = 0;

  // model state
  bit          m_hold = 0;
  logic        m_we   = 0;
  logic [31:0] m_adr  = 0;
  logic [3:0]  m_sel  = 0;
  logic [31:0] m_dat  = 0;
  logic [31:0] m_q[$];
  bit          m_rv    = 0;
  logic [31:0] m_rdata = 0;
  logic        m_err   = 0;
  int          m_wd    = 0;
  bit          m_gnt   = 0;

  ibex_to_wb_master #(
    .ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(MAX), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_i(req), .gnt_o(gnt_o), .we_i(we), .be_i(be), .addr_i(addr), .wdata_i(wdata),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o), .wb_dat_i(dat),
    .wb_ack_i(ack), .wb_err_i(err), .wb_stall_i(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge with inputs applied: check outputs, advance model, move to next negedge.
  task automatic tick();
    bit exp_gnt, iss, bresp, tfire, resp;
    #1;
    exp_gnt = req && (!m_hold || !stall) && ((m_q.size() + int'(m_hold)) < MAX);
    chk("gnt", gnt_o, exp_gnt);
    chk("stb", wb_stb_o, m_hold);
    chk("cyc", wb_cyc_o, (m_hold || m_q.size() != 0));
    chk("rvalid", rvalid_o, m_rv);
    chk("rdata", rdata_o, m_rdata);
    if (m_rv) chk("err", err_o, m_err);
    if (m_hold) begin
      chk("wb_we", wb_we_o, m_we);
      chk("wb_adr", wb_adr_o, m_adr);
      chk("wb_sel", wb_sel_o, m_sel);
      chk("wb_dat", wb_dat_o, m_dat);
    end
    m_gnt = exp_gnt;
    iss   = m_hold && !stall;
    bresp = (ack || err) && (m_q.size() != 0);
    tfire = 0;
`ifdef IBEX_WB_TIMEOUT_EN
    if (m_q.size() != 0 && !bresp) begin
      m_wd++;
      if (m_wd == TO) begin
        tfire = 1;
        m_wd  = 0;
      end
    end else begin
      m_wd = 0;
    end
`endif
    resp = bresp || tfire;
    m_rv = resp;
    if (resp) begin
      m_rdata = tfire ? 32'h0 : dat;
      m_err   = tfire || err;
      void'(m_q.pop_front());
    end
    if (iss) m_q.push_back(m_adr);
    if (exp_gnt) begin
      m_hold = 1; m_we = we; m_adr = addr; m_sel = be; m_dat = wdata;
    end else if (iss) begin
      m_hold = 0;
    end
    if (rst) begin
      m_hold = 0; m_we = 0; m_adr = 0; m_sel = 0; m_dat = 0;
      m_q.delete(); m_rv = 0; m_rdata = 0; m_err = 0; m_wd = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    bit seen;
    rst = 1; req = 0; we = 0; be = 0; addr = 0; wdata = 0; stall = 0; ack = 0; err = 0; dat = 0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_stb", wb_stb_o, 0);
    chk("rst_rvalid", rvalid_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_adr", wb_adr_o, 0);
    @(negedge clk);
    tick();
    rst = 0;

    // single read
    req = 1; addr = 32'h100; be = 4'hF; we = 0;
    #1 chk("single_gnt", gnt_o, 1);
    tick();
    req = 0;
    #1 chk("single_stb", wb_stb_o, 1);
    tick();
    tick();
    ack = 1; dat = 32'hDEADBEEF;
    tick();
    ack = 0;
    #1;
    chk("single_rvalid", rvalid_o, 1);
    chk("single_rdata", rdata_o, 32'hDEADBEEF);
    chk("single_err", err_o, 0);
    chk("single_cyc_drop", wb_cyc_o, 0);
    tick();

    // write held under stall
    req = 1; we = 1; be = 4'h3; addr = 32'h200; wdata = 32'h1234;
    tick();
    req = 0; we = 0; stall = 1;
    repeat (3) tick();
    #1 chk("wr_sel_stall", wb_sel_o, 4'h3);
    stall = 0;
    tick();
    ack = 1; dat = 32'h0;
    tick();
    ack = 0;
    #1 chk("wr_rvalid", rvalid_o, 1);
    tick();
    #1 chk("wr_single", rvalid_o, 0);
    tick();

    // pipelined reads hitting the outstanding limit
    req = 1; addr = 32'h300; tick();
    addr = 32'h304; tick();
    addr = 32'h308;
    #1 chk("full_gnt", gnt_o, 0);
    tick();
    tick();
    ack = 1; dat = 32'h1111; tick();
    ack = 0;
    #1 chk("full_gnt_after_ack", gnt_o, 1);
    tick();
    req = 0; tick();
    ack = 1; dat = 32'h2222; tick();
    dat = 32'h3333; tick();
    ack = 0;
    #1 chk("order_last", rdata_o, 32'h3333);
    tick();
    tick();

    // error on second of two reads
    req = 1; addr = 32'h400; tick();
    addr = 32'h404; tick();
    req = 0; tick();
    ack = 1; dat = 32'h5; tick();
    ack = 0; err = 1; dat = 32'h6; tick();
    err = 0;
    #1 chk("err_second", err_o, 1);
    tick();

    // ack and err together
    req = 1; addr = 32'h500; tick();
    req = 0; tick();
    ack = 1; err = 1; dat = 32'h7; tick();
    ack = 0; err = 0;
    #1 chk("ackerr_err", err_o, 1);
    tick();
    #1 chk("ackerr_single", rvalid_o, 0);
    tick();

    // spurious ack
    ack = 1; dat = 32'h77; tick();
    ack = 0;
    #1 chk("spurious_rvalid", rvalid_o, 0);
    tick();

    // reset with two outstanding
    req = 1; addr = 32'h600; tick();
    addr = 32'h604; tick();
    req = 0; tick();
    rst = 1; tick();
    rst = 0;
    #1 chk("rst_mid_cyc", wb_cyc_o, 0);
    ack = 1; dat = 32'h99; tick();
    tick();
    ack = 0;
    #1 chk("rst_mid_rvalid", rvalid_o, 0);
    tick();

`ifdef IBEX_WB_TIMEOUT_EN
    // hung slave answered by the watchdog
    req = 1; addr = 32'h700; tick();
    req = 0;
    seen = 0;
    for (int i = 0; i < 14; i++) begin
      #1 if (rvalid_o === 1'b1) seen = 1;
      tick();
    end
    chk("timeout_seen", seen, 1);
    #1 chk("timeout_cyc", wb_cyc_o, 0);
    tick();
`else
    seen = 0;
`endif

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      if (!req || m_gnt) begin
        req   = ($urandom_range(0, 2) != 0);
        we    = $urandom_range(0, 1);
        be    = 4'($urandom);
        addr  = $urandom;
        wdata = $urandom;
      end
      stall = ($urandom_range(0, 9) < 3);
      ack   = ($urandom_range(0, 9) < 4);
      err   = ($urandom_range(0, 9) == 0);
      dat   = (m_q.size() != 0) ? (m_q[0] ^ 32'hA5A5_0000) : 32'($urandom);
      rst   = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 0; req = 0; ack = 0; err = 0; stall = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ibex_to_wb_master.md
Name: ibex_to_wb_master

Overview:
- Bridge from the Ibex core-side memory interface (req/gnt/rvalid, instruction or data port) to a pipelined Wishbone B4 master.
- Mirror of the Wishbone-slave-to-Ibex adapter: here the core is the initiator and the Wishbone bus is the target.
- Sits between the ibex_core LSU/IF port and the system interconnect.
- Supports multiple in-flight transactions with in-order responses, Wishbone stall back-pressure and error propagation.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; SEL_W = DATA_W/8.
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered transactions (≥1).
- TIMEOUT_CYCLES, 256, watchdog limit; used only with the optional feature.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- req_i  in  1  core request.
- gnt_o  out  1  request accepted this cycle.
- we_i  in  1  write enable.
- be_i  in  SEL_W  byte enables.
- addr_i  in  ADDR_W  byte address.
- wdata_i  in  DATA_W  write data.
- rvalid_o  out  1  response valid.
- rdata_o  out  DATA_W  read data.
- err_o  out  1  response error, valid with rvalid_o.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_we_o  out  1  Wishbone write enable.
- wb_adr_o  out  ADDR_W  Wishbone address.
- wb_sel_o  out  SEL_W  Wishbone select.
- wb_dat_o  out  DATA_W  Wishbone write data.
- wb_dat_i  in  DATA_W  Wishbone read data.
- wb_ack_i  in  1  Wishbone acknowledge.
- wb_err_i  in  1  Wishbone error.
- wb_stall_i  in  1  Wishbone stall.

Behaviour:
- Reset: all outputs 0; request register, stb_q, cnt_q and response registers cleared.
- Reset mid-operation: cyc drops at the next edge, in-flight transactions are discarded, no rvalid_o is produced for them.
- State: one request holding register (stb_q, we, adr, sel, dat) and issued counter cnt_q, width $clog2(MAX_OUTSTANDING+1).
- gnt_o (combinational) = req_i & (~stb_q | ~wb_stall_i) & ((cnt_q + stb_q) < MAX_OUTSTANDING).
- On gnt_o, the request fields are loaded into the holding register and stb_q=1 from the next cycle.
  - Latency: req_i/gnt_o in cycle N gives wb_stb_o in N+1.
- wb_stb_o = stb_q. wb_we_o/adr/sel/dat_o are driven from the holding register and stay stable while wb_stb_o & wb_stall_i.
- Issue event: stb_q & ~wb_stall_i.
  - cnt_q increments unless a response arrives in the same cycle.
  - stb_q clears unless a new grant occurs in the same cycle (back-to-back issue allowed).
- Response event: (wb_ack_i | wb_err_i) & cnt_q != 0.
  - cnt_q decrements.
  - Next cycle: rvalid_o=1, rdata_o=wb_dat_i captured, err_o=wb_err_i.
  - Latency: ack in M gives rvalid_o in M+1.
- Simultaneous issue and response: cnt_q unchanged.
- ack and err in the same cycle: a single response with err_o=1.
- Spurious ack/err with cnt_q==0: ignored, no rvalid_o.
- rvalid_o is a single-cycle pulse per response; responses return in issue order. rdata_o holds its value between pulses.
- wb_cyc_o = stb_q | (cnt_q != 0). Deasserts the cycle after the last response when no request is pending.
- Full condition: cnt_q + stb_q == MAX_OUTSTANDING forces gnt_o=0 even while req_i is asserted.

Optional Feature:
- Macro IBEX_WB_TIMEOUT_EN.
- Defined:
  - A watchdog counter runs while cnt_q != 0 and no response arrives, and clears on any response or when cnt_q==0.
  - When it reaches TIMEOUT_CYCLES, the block generates a synthetic response (rvalid_o=1, err_o=1, rdata_o=0 next cycle), decrements cnt_q and restarts the counter.
  - If cnt_q becomes 0 with stb_q=0, cyc drops.
- Not defined: no watchdog logic; a hung slave stalls the core indefinitely.

Test Plan:
- Single read: req_i addr=0x100, slave stall=0, ack 2 cycles after stb with dat=0xDEADBEEF -> gnt_o same cycle, stb N+1, rvalid_o=1 rdata_o=0xDEADBEEF err_o=0 one cycle after ack, cyc drops after.
- Write with stall: we=1, be=0x3, wdata=0x1234, wb_stall_i=1 for 3 cycles -> adr/sel/dat_o stable for 4 strobe cycles, cnt_q increments only when stall=0, single rvalid_o.
- Pipelined full: MAX_OUTSTANDING=2, 3 back-to-back reads, acks delayed -> third gnt_o held 0 until first ack; rvalid_o data in issue order.
- Error: wb_err_i on second of two reads -> rvalid_o err_o=0 then err_o=1; ack+err same cycle gives one response with err_o=1.
- Spurious ack with cnt_q=0 -> no rvalid_o; rst_i asserted with 2 outstanding -> next cycle cyc/stb=0, cnt_q=0, no rvalid_o from late acks.
- With IBEX_WB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks -> rvalid_o=1 err_o=1 rdata_o=0 after 8 idle cycles, cyc deasserts.
